ram_bist_ctrl: RTL and testbench



---
 rtl/ram_bist_pkg.sv | 37 +++
 rtl/ram_bist_if.sv | 37 +++
 rtl/ram_bist_chk.sv | 79 +++++++
 rtl/ram_bist_ctrl.sv | 158 +++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_bist_pkg.sv
// ============================================================================
// Module      : ram_bist_pkg
// Description : Shared types, latency limits and data pattern for the RAM BIST.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_bist_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } bist_state_e;

   localparam int c_rd_lat_min = 1;
   localparam int c_rd_lat_max = 2;

   // Out-of-range latencies are pulled to the nearest legal value.
   function automatic int legal_rd_latency(input int lat);
      if (lat < c_rd_lat_min) return c_rd_lat_min;
      if (lat > c_rd_lat_max) return c_rd_lat_max;
      return lat;
   endfunction

   // Address zero-extended to 64 bits; callers truncate to their data width.
   function automatic logic [63:0] bist_pattern(input logic [31:0] addr, input logic inv);
      logic [63:0] v;
      v = {32'd0, addr};
      return inv ? ~v : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_bist_if.sv
// ============================================================================
// Module      : ram_bist_if
// Description : Control/status and RAM port bundle of the BIST sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_bist_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 9
) ();
   logic                  start;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_waddr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [ADDR_WIDTH-1:0] ram_raddr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  busy;
   logic                  done;
   logic                  pass;
   logic [ADDR_WIDTH+1:0] err_count;
   logic [ADDR_WIDTH-1:0] first_err_addr;

   modport master (
      input  start, ram_rdata,
      output ram_we, ram_waddr, ram_wdata, ram_raddr,
             busy, done, pass, err_count, first_err_addr
   );

   modport slave (
      output start, ram_rdata,
      input  ram_we, ram_waddr, ram_wdata, ram_raddr,
             busy, done, pass, err_count, first_err_addr
   );
endinterface

`default_nettype wire

// File: rtl/ram_bist_chk.sv
// ============================================================================
// Module      : ram_bist_chk
// Description : Read-latency delay line, read-data comparator and error stats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_bist_chk
   import ram_bist_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 9,
   parameter int RD_LATENCY = 1
) (
   input  wire logic                  clka,
   input  wire logic                  rst_n,
   input  wire logic                  clear,
   input  wire logic                  flush,
   input  wire logic                  rd_valid,
   input  wire logic [DATA_WIDTH-1:0] rd_exp,
   input  wire logic [ADDR_WIDTH-1:0] rd_addr,
   input  wire logic [DATA_WIDTH-1:0] rdata,
   output logic                       mismatch,
   output logic [ADDR_WIDTH+1:0]      err_count,
   output logic [ADDR_WIDTH-1:0]      first_err_addr
);

   localparam int c_depth = legal_rd_latency(RD_LATENCY);

   typedef struct packed {
      logic                  vld;
      logic [DATA_WIDTH-1:0] exp;
      logic [ADDR_WIDTH-1:0] addr;
   } stage_t;

   stage_t w_stage_in [c_depth];
   stage_t r_stage    [c_depth];
   stage_t w_tail;

   for (genvar gi = 0; gi < c_depth; gi++) begin : g_link
      if (gi == 0) begin : g_head
         assign w_stage_in[gi] = '{vld: rd_valid, exp: rd_exp, addr: rd_addr};
      end else begin : g_body
         assign w_stage_in[gi] = r_stage[gi-1];
      end
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_depth; i++) r_stage[i] <= '0;
      end else begin
         for (int i = 0; i < c_depth; i++) begin
            r_stage[i] <= '{vld:  w_stage_in[i].vld & ~flush,
                            exp:  w_stage_in[i].exp,
                            addr: w_stage_in[i].addr};
         end
      end
   end

   assign w_tail   = r_stage[c_depth-1];
   assign mismatch = w_tail.vld & (rdata != w_tail.exp);

   // A new test clears the statistics even if a stale compare lands this cycle.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (clear) begin
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (mismatch) begin
         err_count <= err_count + 1'b1;
         if (err_count == '0) first_err_addr <= w_tail.addr;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ram_bist_ctrl.sv
// ============================================================================
// Module      : ram_bist_ctrl
// Description : Two-pass write/read/compare BIST sequencer for a dual-port RAM.
//               Optional RAM_BIST_STOP_ON_ERR_EN: abort to DONE on first error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_bist_ctrl
   import ram_bist_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 9,
   parameter int RD_LATENCY = 1
) (
   input  wire logic  clka,
   input  wire logic  rst_n,
   ram_bist_if.master bus
);

   localparam int c_lat = legal_rd_latency(RD_LATENCY);
   localparam logic [ADDR_WIDTH-1:0] c_drain_last = ADDR_WIDTH'(c_lat - 1);
`ifdef RAM_BIST_STOP_ON_ERR_EN
   localparam logic c_stop_on_err = 1'b1;
`else
   localparam logic c_stop_on_err = 1'b0;
`endif

   bist_state_e r_state;
   bist_state_e w_next_state;

   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  r_pass_idx;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [ADDR_WIDTH-1:0] r_raddr;
   logic                  r_rd_valid;
   logic [DATA_WIDTH-1:0] r_rd_exp;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_accept;
   logic                  w_cnt_last;
   logic                  w_drain_last;
   logic                  w_mismatch;
   logic                  w_abort;
   logic                  w_we_d;
   logic                  w_rd_valid_d;
   logic                  w_busy_d;
   logic                  w_done_d;
   logic [DATA_WIDTH-1:0] w_pat;
   logic [ADDR_WIDTH+1:0] w_err_count;
   logic [ADDR_WIDTH-1:0] w_first_err_addr;

   assign w_accept     = bus.start & ((r_state == IDLE) | (r_state == DONE));
   assign w_cnt_last   = (r_cnt == '1);
   assign w_drain_last = (r_cnt == c_drain_last);
   assign w_abort      = w_mismatch & c_stop_on_err;
   assign w_pat        = DATA_WIDTH'(bist_pattern(32'(r_cnt), r_pass_idx));

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:    if (w_accept) w_next_state = WRITE;
         WRITE:   if (w_abort) w_next_state = DONE;
                  else if (w_cnt_last) w_next_state = READ;
         READ:    if (w_abort) w_next_state = DONE;
                  else if (w_cnt_last) w_next_state = DRAIN;
         DRAIN:   if (w_abort) w_next_state = DONE;
                  else if (w_drain_last) w_next_state = r_pass_idx ? DONE : WRITE;
         DONE:    if (w_accept) w_next_state = WRITE;
         default: w_next_state = IDLE;
      endcase
   end

   // Next values for the registered outputs; done is held in DONE until restart.
   always_comb begin
      w_we_d       = (r_state == WRITE) & ~w_abort;
      w_rd_valid_d = (r_state == READ)  & ~w_abort;
      w_busy_d     = (w_next_state == WRITE) | (w_next_state == READ) |
                     (w_next_state == DRAIN);
      w_done_d     = (r_state == DONE) ? ~w_accept : w_abort;
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_pass_idx <= 1'b0;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_raddr    <= '0;
         r_rd_valid <= 1'b0;
         r_rd_exp   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_we       <= w_we_d;
         r_rd_valid <= w_rd_valid_d;
         r_busy     <= w_busy_d;
         r_done     <= w_done_d;
         if (r_state == WRITE) begin
            r_waddr <= r_cnt;
            r_wdata <= w_pat;
         end
         if (r_state == READ) begin
            r_raddr  <= r_cnt;
            r_rd_exp <= w_pat;
         end
         if (w_accept) begin
            r_cnt      <= '0;
            r_pass_idx <= 1'b0;
         end else if ((r_state == DRAIN) && w_drain_last) begin
            r_cnt      <= '0;
            r_pass_idx <= 1'b1;
         end else if ((r_state == WRITE) || (r_state == READ) || (r_state == DRAIN)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   ram_bist_chk #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RD_LATENCY (c_lat)
   ) u_chk (
      .clka           (clka),
      .rst_n          (rst_n),
      .clear          (w_accept),
      .flush          (w_accept | w_abort),
      .rd_valid       (r_rd_valid),
      .rd_exp         (r_rd_exp),
      .rd_addr        (r_raddr),
      .rdata          (bus.ram_rdata),
      .mismatch       (w_mismatch),
      .err_count      (w_err_count),
      .first_err_addr (w_first_err_addr)
   );

   assign bus.ram_we         = r_we;
   assign bus.ram_waddr      = r_waddr;
   assign bus.ram_wdata      = r_wdata;
   assign bus.ram_raddr      = r_raddr;
   assign bus.busy           = r_busy;
   assign bus.done           = r_done;
   assign bus.pass           = r_done & (w_err_count == '0);
   assign bus.err_count      = w_err_count;
   assign bus.first_err_addr = w_first_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
// ============================================================================
// Module      : tb_ram_bist_ctrl
// Description : Bench for ram_bist_ctrl with RAM models at read latency 1 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_bist_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   fault_mode = 0;     // 0 none, 1 flip bit0 on addr 5, 2 stuck-at-0
   int   n_assert = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   logic          start_v [2];
   logic          we_v    [2];
   logic          busy_v  [2];
   logic          done_v  [2];
   logic          pass_v  [2];
   logic [AW-1:0] waddr_v [2];
   logic [AW-1:0] raddr_v [2];
   logic [AW-1:0] ferr_v  [2];
   logic [DW-1:0] wdata_v [2];
   logic [AW+1:0] err_v   [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      ram_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
      logic [DW-1:0] mem [DEPTH];
      logic [DW-1:0] q1;
      logic [DW-1:0] q2;

      ram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(gi + 1)) u_dut (
         .clka  (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );

      always @(posedge clk) begin
         if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
         if (fault_mode == 2) q1 <= '0;
         else q1 <= mem[bus.ram_raddr] ^
                    {{(DW-1){1'b0}}, (fault_mode == 1) && (bus.ram_raddr == AW'(5))};
         q2 <= q1;
      end

      assign bus.start     = start_v[gi];
      assign bus.ram_rdata = (gi == 0) ? q1 : q2;
      assign we_v[gi]      = bus.ram_we;
      assign busy_v[gi]    = bus.busy;
      assign done_v[gi]    = bus.done;
      assign pass_v[gi]    = bus.pass;
      assign waddr_v[gi]   = bus.ram_waddr;
      assign raddr_v[gi]   = bus.ram_raddr;
      assign ferr_v[gi]    = bus.first_err_addr;
      assign wdata_v[gi]   = bus.ram_wdata;
      assign err_v[gi]     = bus.err_count;
   end

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;
   wr_t wq[$];

   typedef struct {
      int   sel;
      int   fault;
      int   exp_cyc;
      logic exp_pass;
      int   exp_err;
      int   exp_ferr;
      int   n_wr;
   } vec_t;
   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_quiet(input int sel, input string tag);
      check({tag, " ram_we"}, 32'(we_v[sel]), 0);
      check({tag, " busy"}, 32'(busy_v[sel]), 0);
      check({tag, " done"}, 32'(done_v[sel]), 0);
      check({tag, " pass"}, 32'(pass_v[sel]), 0);
      check({tag, " err_count"}, 32'(err_v[sel]), 0);
      check({tag, " first_err_addr"}, 32'(ferr_v[sel]), 0);
      check({tag, " ram_waddr"}, 32'(waddr_v[sel]), 0);
      check({tag, " ram_wdata"}, 32'(wdata_v[sel]), 0);
      check({tag, " ram_raddr"}, 32'(raddr_v[sel]), 0);
   endtask

   task automatic observe_write(input int sel, input string tag);
      wr_t w;
      if (we_v[sel]) begin
         if (wq.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s write: unexpected write addr 0x%0h data 0x%0h, expected none",
                     tag, waddr_v[sel], wdata_v[sel]);
         end else begin
            w = wq.pop_front();
            check({tag, " write"}, 32'({waddr_v[sel], wdata_v[sel]}), 32'({w.addr, w.data}));
         end
      end
   endtask

   task automatic run_test(input int sel, input int fault, input int exp_cyc,
                           input logic exp_pass, input int exp_err, input int exp_ferr,
                           input int n_wr, input int pulse_at, input string tag);
      int   n;
      logic seen;
      logic [DW-1:0] d;
      fault_mode = fault;
      wq.delete();
      for (int p = 0; p < n_wr / DEPTH; p++) begin
         for (int a = 0; a < DEPTH; a++) begin
            d = DW'(a);
            wq.push_back('{addr: AW'(a), data: (p == 1) ? ~d : d});
         end
      end
      @(negedge clk);
      start_v[sel] = 1'b1;
      @(posedge clk);
      #1;
      start_v[sel] = 1'b0;
      check({tag, " busy after start"}, 32'(busy_v[sel]), 1);
      check({tag, " done cleared"}, 32'(done_v[sel]), 0);
      check({tag, " pass cleared"}, 32'(pass_v[sel]), 0);
      check({tag, " err cleared"}, 32'(err_v[sel]), 0);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         start_v[sel] = (n == pulse_at);
         observe_write(sel, tag);
         if (done_v[sel]) seen = 1'b1;
      end
      start_v[sel] = 1'b0;
      if (!seen) begin
         n_assert++;
         n_fail++;
         $display("FAIL %s timeout: done not seen in %0d cycles, expected at %0d", tag, n, exp_cyc);
      end else begin
         check({tag, " done latency"}, 32'(n), 32'(exp_cyc));
      end
      check({tag, " busy at done"}, 32'(busy_v[sel]), 0);
      check({tag, " pass"}, 32'(pass_v[sel]), 32'(exp_pass));
      check({tag, " err_count"}, 32'(err_v[sel]), 32'(exp_err));
      check({tag, " first_err_addr"}, 32'(ferr_v[sel]), 32'(exp_ferr));
      check({tag, " writes left"}, 32'(wq.size()), 0);
   endtask

   initial begin
      start_v[0] = 1'b0;
      start_v[1] = 1'b0;
      // sel, fault, done latency, pass, err_count, first_err_addr, writes
`ifdef RAM_BIST_STOP_ON_ERR_EN
      vecs = '{'{0, 0, 67, 1'b1, 0, 0, 32}, '{1, 0, 69, 1'b1, 0, 0, 32},
               '{0, 1, 24, 1'b0, 1, 5, 16}, '{1, 1, 25, 1'b0, 1, 5, 16},
               '{0, 2, 20, 1'b0, 1, 1, 16}, '{1, 2, 21, 1'b0, 1, 1, 16}};
`else
      vecs = '{'{0, 0, 67, 1'b1, 0, 0, 32}, '{1, 0, 69, 1'b1, 0, 0, 32},
               '{0, 1, 67, 1'b0, 2, 5, 32}, '{1, 1, 69, 1'b0, 2, 5, 32},
               '{0, 2, 67, 1'b0, 31, 1, 32}, '{1, 2, 69, 1'b0, 31, 1, 32}};
`endif

      repeat (3) @(posedge clk);
      #1;
      check_quiet(0, "reset lat1");
      check_quiet(1, "reset lat2");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_test(vecs[i].sel, vecs[i].fault, vecs[i].exp_cyc, vecs[i].exp_pass,
                  vecs[i].exp_err, vecs[i].exp_ferr, vecs[i].n_wr, 0,
                  $sformatf("vec%0d", i));
      end

      // Start pulsed mid-WRITE must be ignored without disturbing timing.
      run_test(0, 0, 67, 1'b1, 0, 0, 32, 10, "start_in_write");

      // Asynchronous reset in the middle of READ.
      fault_mode = 0;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("mid-read raddr", 32'(raddr_v[0]), 3);
      #2;
      rst_n = 1'b0;
      #1;
      check_quiet(0, "async reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check("post-reset ram_we", 32'(we_v[0]), 0);
         check("post-reset busy", 32'(busy_v[0]), 0);
      end
      run_test(0, 0, 67, 1'b1, 0, 0, 32, 0, "after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
